// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fsm_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with synchronous flush; DEPTH must be a power of two.
module if_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en_s, rd_en_s;

  assign rd_en_s = pop_i && (count_q != {CW{1'b0}});
  assign wr_en_s = push_i && ((count_q != FULL_C) || rd_en_s);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (rd_en_s) rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      case ({wr_en_s, rd_en_s})
        2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (wr_en_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == {CW{1'b0}});
  assign full_o  = (count_q == FULL_C);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC next-value logic, imem request/response, decode buffer.
// Optional macro IF_BYPASS_EN: same-cycle response-to-decode bypass when the buffer is empty.
module instr_fetch
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fsm_state_t    state_q, state_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] tag_cnt_s, buf_cnt_s;
  logic          tag_empty_s, tag_full_s, buf_empty_s, buf_full_s;
  logic [31:0]   tag_pc_s;
  fetch_entry_t  buf_in_s, buf_out_s;
  logic          accept_s, resp_s, rv_hit_s, byp_s, buf_push_s, buf_pop_s;
  logic [CW:0]   occ_s;

  // The tag FIFO count is the outstanding-fetch count; it is cleared with the flush.
  assign rv_hit_s   = imem_rvalid_i && !tag_empty_s;
  assign resp_s     = (state_q == RUN) && rv_hit_s && !redirect_i;
  assign buf_pop_s  = !buf_empty_s && if_ready_i;
  assign buf_push_s = resp_s && !(byp_s && if_ready_i);
  assign buf_in_s   = '{pc: tag_pc_s, instr: imem_rdata_i};

  // A slot vacated by decode this cycle counts as free so DEPTH=2 sustains one fetch per cycle.
  assign occ_s = {1'b0, tag_cnt_s} + {1'b0, buf_cnt_s} - {{CW{1'b0}}, buf_pop_s};

  assign imem_req_o  = (state_q == RUN) && !redirect_i && !tag_full_s &&
                       (!buf_full_s || buf_pop_s) && (occ_s < DEPTH_C);
  assign imem_addr_o = word_align(pc_i);
  assign accept_s    = imem_req_o && imem_gnt_i;

  always_comb begin
    if (rst_i) begin
      pc_next_o = pc_i;
    end else if (redirect_i) begin
      pc_next_o = redirect_pc_i;
    end else if (accept_s) begin
      pc_next_o = pc_i + 32'(INSTR_BYTES);
    end else begin
      pc_next_o = pc_i;
    end
  end

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_i) begin
          disc_d  = tag_cnt_s - {{(CW-1){1'b0}}, rv_hit_s};
          state_d = (disc_d != {CW{1'b0}}) ? FLUSH : RUN;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (imem_rvalid_i && (disc_q != {CW{1'b0}})) begin
          disc_d = disc_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          disc_d = disc_q;
        end
        state_d = (disc_d == {CW{1'b0}}) ? RUN : FLUSH;
      end
      default: begin
        state_d = IDLE;
        disc_d  = {CW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      disc_q  <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
    end
  end

  always_comb begin
    byp_s      = 1'b0;
    if_valid_o = !buf_empty_s;
    if_instr_o = buf_empty_s ? 32'h0000_0000 : buf_out_s.instr;
    if_pc_o    = buf_empty_s ? 32'h0000_0000 : buf_out_s.pc;
`ifdef IF_BYPASS_EN
    if (resp_s && buf_empty_s) begin
      byp_s      = 1'b1;
      if_valid_o = 1'b1;
      if_instr_o = imem_rdata_i;
      if_pc_o    = tag_pc_s;
    end else begin
      byp_s = 1'b0;
    end
`endif
  end

  if_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (accept_s),
    .data_i  (imem_addr_o),
    .pop_i   (resp_s),
    .data_o  (tag_pc_s),
    .full_o  (tag_full_s),
    .empty_o (tag_empty_s),
    .count_o (tag_cnt_s)
  );

  if_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_buf_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (buf_push_s),
    .data_i  (buf_in_s),
    .pop_i   (buf_pop_s),
    .data_o  (buf_out_s),
    .full_o  (buf_full_s),
    .empty_o (buf_empty_s),
    .count_o (buf_cnt_s)
  );

endmodule
